// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM encoding,
// special-result classes and iteration-count helpers.
package muldiv_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_STEP  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Results that bypass the iterative datapath
    typedef enum logic [1:0] {
        SPC_NONE = 2'd0,
        SPC_DIV0 = 2'd1,   // lo = all ones, hi = raw dividend
        SPC_OVF  = 2'd2    // lo = MIN, hi = 0
    } special_t;

    // Iterations per operation
    function automatic int unsigned iter_count(input int unsigned width, input int unsigned step);
        return width / step;
    endfunction

    // Iteration counter width, at least one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bus between EXE and the multiply/divide unit.
//   master: EXE side (drives request, flush, out_ready)
//   slave : unit side (drives in_ready, busy, out_valid, out_hi, out_lo)
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_div;
    logic             in_sign;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             flush;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_hi;
    logic [WIDTH-1:0] out_lo;

    modport master (
        output in_valid, in_div, in_sign, src1, src2, flush, out_ready,
        input  in_ready, busy, out_valid, out_hi, out_lo
    );

    modport slave (
        input  in_valid, in_div, in_sign, src1, src2, flush, out_ready,
        output in_ready, busy, out_valid, out_hi, out_lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
//   is_div   : 0 = STEP shift-add stages, 1 = STEP restoring compare-subtract stages
//   opnd     : multiplicand magnitude (mul) or divisor magnitude (div)
//   hi_in    : product high half (mul) or partial remainder (div)
//   lo_in    : remaining multiplier bits / low product (mul) or dividend / quotient (div)
//   hi_nxt_c, lo_nxt_c : accumulator after STEP bits
module muldiv_step #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] opnd,
    input  logic [WIDTH:0]   hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH:0]   hi_nxt_c,
    output logic [WIDTH-1:0] lo_nxt_c
);

    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH+1:0] r_wide;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   sum;

    // Unrolled STEP sub-iterations
    always_comb begin
        hi     = hi_in;
        lo     = lo_in;
        r_wide = '0;
        diff   = '0;
        sum    = '0;
        for (int i = 0; i < int'(STEP); i++) begin
            if (is_div) begin
                // Shift next dividend bit into the remainder, keep the difference if non-negative
                r_wide = {hi, lo[WIDTH-1]};
                diff   = r_wide - {2'b00, opnd};
                if (!diff[WIDTH+1]) begin
                    hi = diff[WIDTH:0];
                    lo = {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi = r_wide[WIDTH:0];
                    lo = {lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                // Add multiplicand on multiplier LSB, then shift the whole accumulator right
                sum = {1'b0, hi[WIDTH-1:0]} + (lo[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
                hi  = {1'b0, sum[WIDTH:1]};
                lo  = {sum[0], lo[WIDTH-1:1]};
            end
        end
        hi_nxt_c = hi;
        lo_nxt_c = lo;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit, STEP result bits per cycle.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : in_valid/in_ready request with in_div, in_sign, src1, src2;
//                 flush abort; busy; out_valid/out_ready result with out_hi, out_lo
//                 (MULT: product high/low, DIV: remainder/quotient)
// Accept at cycle 0 gives out_valid from cycle N+1, N = WIDTH/STEP.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned STEP  = DEF_STEP
) (
    input  logic    clk,
    input  logic    resetn,
    muldiv_if.slave bus
);

    localparam int unsigned N  = iter_count(WIDTH, STEP);
    localparam int unsigned CW = cnt_width(N);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    if (!(STEP == 1 || STEP == 2 || STEP == 4) || (WIDTH % STEP) != 0) begin : g_bad_param
        $error("muldiv_unit: STEP must be 1, 2 or 4 and divide WIDTH");
    end

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH:0]   acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] src1_q;
    logic             div_q;
    logic             neg_main_q;
    logic             neg_rem_q;
    special_t         spc_q;

    logic             s1_neg_c;
    logic             s2_neg_c;
    logic [WIDTH-1:0] mag1_c;
    logic [WIDTH-1:0] mag2_c;
    special_t         spc_c;
    logic [WIDTH:0]   hi_nxt_c;
    logic [WIDTH-1:0] lo_nxt_c;
    logic [W2-1:0]    prod_c;
    logic [WIDTH-1:0] res_hi_c;
    logic [WIDTH-1:0] res_lo_c;

    // Operand magnitudes and special-case classification at accept
    always_comb begin
        s1_neg_c = bus.in_sign & bus.src1[WIDTH-1];
        s2_neg_c = bus.in_sign & bus.src2[WIDTH-1];
        mag1_c   = s1_neg_c ? (~bus.src1 + WIDTH'(1)) : bus.src1;
        mag2_c   = s2_neg_c ? (~bus.src2 + WIDTH'(1)) : bus.src2;
        spc_c    = SPC_NONE;
        if (bus.in_div) begin
            if (bus.src2 == '0) begin
                spc_c = SPC_DIV0;
            end else if (bus.in_sign && bus.src1 == MIN_VAL && bus.src2 == '1) begin
                spc_c = SPC_OVF;
            end
        end
    end

    muldiv_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .is_div   (div_q),
        .opnd     (opnd_q),
        .hi_in    (acc_hi_q),
        .lo_in    (acc_lo_q),
        .hi_nxt_c (hi_nxt_c),
        .lo_nxt_c (lo_nxt_c)
    );

    // Sign fix-up and special-result override, registered on DONE entry
    always_comb begin
        prod_c   = {acc_hi_q[WIDTH-1:0], acc_lo_q};
        res_hi_c = '0;
        res_lo_c = '0;
        if (!div_q) begin
            if (neg_main_q) begin
                prod_c = ~prod_c + W2'(1);
            end
            res_hi_c = prod_c[W2-1:WIDTH];
            res_lo_c = prod_c[WIDTH-1:0];
        end else begin
            res_lo_c = neg_main_q ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
            res_hi_c = neg_rem_q ? (~acc_hi_q[WIDTH-1:0] + WIDTH'(1)) : acc_hi_q[WIDTH-1:0];
            if (spc_q == SPC_DIV0) begin
                res_lo_c = '1;
                res_hi_c = src1_q;
            end else if (spc_q == SPC_OVF) begin
                res_lo_c = MIN_VAL;
                res_hi_c = '0;
            end
        end
    end

    // FSM, iteration state and registered outputs; flush overrides everything
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            opnd_q        <= '0;
            acc_hi_q      <= '0;
            acc_lo_q      <= '0;
            src1_q        <= '0;
            div_q         <= 1'b0;
            neg_main_q    <= 1'b0;
            neg_rem_q     <= 1'b0;
            spc_q         <= SPC_NONE;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_hi    <= '0;
            bus.out_lo    <= '0;
        end else if (bus.flush) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state_q      <= ST_RUN;
                        cnt_q        <= '0;
                        opnd_q       <= bus.in_div ? mag2_c : mag1_c;
                        acc_lo_q     <= bus.in_div ? mag1_c : mag2_c;
                        acc_hi_q     <= '0;
                        src1_q       <= bus.src1;
                        div_q        <= bus.in_div;
                        neg_main_q   <= s1_neg_c ^ s2_neg_c;
                        neg_rem_q    <= s1_neg_c;
                        spc_q        <= spc_c;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_hi_q <= hi_nxt_c;
                    acc_lo_q <= lo_nxt_c;
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (!bus.out_valid) begin
                        bus.out_hi    <= res_hi_c;
                        bus.out_lo    <= res_lo_c;
                        bus.out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        state_q       <= ST_IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomised bench for muldiv_unit: a STEP=1 and a STEP=4 instance,
// expectations queued at issue and compared when the result appears.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) b1 ();
    muldiv_if #(.WIDTH(32)) b4 ();

    muldiv_unit #(.WIDTH(32), .STEP(1)) u_dut1 (.clk(clk), .resetn(resetn), .bus(b1));
    muldiv_unit #(.WIDTH(32), .STEP(4)) u_dut4 (.clk(clk), .resetn(resetn), .bus(b4));

    // Shared drive, steered to one instance by sel4
    logic        sel4;
    logic        drv_valid, drv_div, drv_sign, drv_flush, drv_out_ready;
    logic [31:0] drv_src1, drv_src2;

    assign b1.in_valid  = drv_valid & ~sel4;
    assign b4.in_valid  = drv_valid & sel4;
    assign b1.out_ready = drv_out_ready & ~sel4;
    assign b4.out_ready = drv_out_ready & sel4;
    assign b1.in_div    = drv_div;
    assign b4.in_div    = drv_div;
    assign b1.in_sign   = drv_sign;
    assign b4.in_sign   = drv_sign;
    assign b1.src1      = drv_src1;
    assign b4.src1      = drv_src1;
    assign b1.src2      = drv_src2;
    assign b4.src2      = drv_src2;
    assign b1.flush     = drv_flush & ~sel4;
    assign b4.flush     = drv_flush & sel4;

    logic        obs_in_ready, obs_busy, obs_out_valid;
    logic [31:0] obs_out_hi, obs_out_lo;
    assign obs_in_ready  = sel4 ? b4.in_ready  : b1.in_ready;
    assign obs_busy      = sel4 ? b4.busy      : b1.busy;
    assign obs_out_valid = sel4 ? b4.out_valid : b1.out_valid;
    assign obs_out_hi    = sel4 ? b4.out_hi    : b1.out_hi;
    assign obs_out_lo    = sel4 ? b4.out_lo    : b1.out_lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;
    res_t sb_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!obs_in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, ".in_ready"}, 64'(obs_in_ready), 64'd1);
    endtask

    // Issue one op, check latency, optional back-pressure hold, result and drain
    task automatic do_op(input string name, input logic div, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int stall);
        int   lat;
        int   exp_lat;
        res_t e;
        exp_lat = sel4 ? 9 : 33;
        wait_ready(name);
        drv_valid = 1'b1;
        drv_div   = div;
        drv_sign  = sgn;
        drv_src1  = a;
        drv_src2  = b;
        sb_q.push_back('{hi: eh, lo: el});
        @(posedge clk); #1;
        drv_valid = 1'b0;
        drv_src1  = $urandom;
        drv_src2  = $urandom;
        drv_div   = ~div;
        drv_sign  = ~sgn;
        chk({name, ".busy"}, 64'(obs_busy), 64'd1);
        chk({name, ".in_ready_low"}, 64'(obs_in_ready), 64'd0);
        lat = 0;
        while (!obs_out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, ".latency"}, 64'(lat), 64'(exp_lat));
        e = sb_q.pop_front();
        for (int i = 0; i < stall; i++) begin
            chk({name, ".hold_valid"}, 64'(obs_out_valid), 64'd1);
            chk({name, ".hold_hi"}, 64'(obs_out_hi), 64'(e.hi));
            chk({name, ".hold_lo"}, 64'(obs_out_lo), 64'(e.lo));
            chk({name, ".hold_in_ready"}, 64'(obs_in_ready), 64'd0);
            @(posedge clk); #1;
        end
        chk({name, ".hi"}, 64'(obs_out_hi), 64'(e.hi));
        chk({name, ".lo"}, 64'(obs_out_lo), 64'(e.lo));
        drv_out_ready = 1'b1;
        @(posedge clk); #1;
        drv_out_ready = 1'b0;
        chk({name, ".drain_valid"}, 64'(obs_out_valid), 64'd0);
        chk({name, ".drain_in_ready"}, 64'(obs_in_ready), 64'd1);
        chk({name, ".drain_busy"}, 64'(obs_busy), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] p;
        logic        seen;
        int          n;

        sel4          = 1'b0;
        drv_valid     = 1'b0;
        drv_div       = 1'b0;
        drv_sign      = 1'b0;
        drv_flush     = 1'b0;
        drv_out_ready = 1'b0;
        drv_src1      = '0;
        drv_src2      = '0;
        resetn        = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 64'(obs_in_ready), 64'd1);
        chk("rst.busy", 64'(obs_busy), 64'd0);
        chk("rst.out_valid", 64'(obs_out_valid), 64'd0);
        chk("rst.out_hi", 64'(obs_out_hi), 64'd0);
        chk("rst.out_lo", 64'(obs_out_lo), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Directed STEP=1 cases
        do_op("mult_m3x5",   1'b0, 1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0);
        do_op("divu_100_7",  1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       0);
        do_op("div_m7_2",    1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        do_op("div_7_m2",    1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 0);
        do_op("div_5_0",     1'b1, 1'b1, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 0);
        do_op("div_m5_0",    1'b1, 1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 0);
        do_op("div_ovf",     1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 0);
        do_op("divu_min_m1", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        0);
        do_op("mult_min2",   1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        0);
        do_op("multu_max",   1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3);

        // Random ops against bench arithmetic
        for (int k = 0; k < 8; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k >= 4) rb = rb >> (k * 4);
            if (rb == 32'd0) rb = 32'd3;
            if (rb == 32'hFFFFFFFF) rb = 32'd9;
            case (k % 4)
                0: begin
                    p = 64'(ra) * 64'(rb);
                    do_op("rnd_multu", 1'b0, 1'b0, ra, rb, p[63:32], p[31:0], 0);
                end
                1: begin
                    p = 64'($signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb}));
                    do_op("rnd_mult", 1'b0, 1'b1, ra, rb, p[63:32], p[31:0], 0);
                end
                2: begin
                    do_op("rnd_divu", 1'b1, 1'b0, ra, rb, ra % rb, ra / rb, 0);
                end
                default: begin
                    do_op("rnd_div", 1'b1, 1'b1, ra, rb,
                          32'($signed(ra) % $signed(rb)), 32'($signed(ra) / $signed(rb)), 0);
                end
            endcase
        end

        // Flush at cycle 10 of a DIV: back to IDLE, result never presented
        wait_ready("flush_run");
        drv_valid = 1'b1;
        drv_div   = 1'b1;
        drv_sign  = 1'b0;
        drv_src1  = 32'd1000;
        drv_src2  = 32'd3;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        drv_flush = 1'b1;
        @(posedge clk); #1;
        drv_flush = 1'b0;
        chk("flush_run.in_ready", 64'(obs_in_ready), 64'd1);
        chk("flush_run.busy", 64'(obs_busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= obs_out_valid;
            @(posedge clk); #1;
        end
        chk("flush_run.no_out_valid", 64'(seen), 64'd0);
        do_op("after_flush_6x7", 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 0);

        // Flush beats out_ready while the result is presented
        wait_ready("flush_done");
        drv_valid = 1'b1;
        drv_div   = 1'b0;
        drv_sign  = 1'b0;
        drv_src1  = 32'd9;
        drv_src2  = 32'd9;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        n = 0;
        while (!obs_out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("flush_done.valid_seen", 64'(obs_out_valid), 64'd1);
        drv_flush     = 1'b1;
        drv_out_ready = 1'b1;
        @(posedge clk); #1;
        drv_flush     = 1'b0;
        drv_out_ready = 1'b0;
        chk("flush_done.valid_drop", 64'(obs_out_valid), 64'd0);
        chk("flush_done.in_ready", 64'(obs_in_ready), 64'd1);

        // Flush beats accept in IDLE
        drv_valid = 1'b1;
        drv_flush = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        drv_flush = 1'b0;
        chk("flush_accept.busy", 64'(obs_busy), 64'd0);
        chk("flush_accept.in_ready", 64'(obs_in_ready), 64'd1);

        // STEP=4 instance
        sel4 = 1'b1;
        do_op("s4_mult_6x7", 1'b0, 1'b1, 32'd6, 32'd7, 32'd0, 32'd42, 0);
        do_op("s4_div_m7_2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1);

        // Async reset mid-RUN
        wait_ready("s4_reset");
        drv_valid = 1'b1;
        drv_div   = 1'b0;
        drv_sign  = 1'b0;
        drv_src1  = 32'd3;
        drv_src2  = 32'd3;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("s4_reset.busy_before", 64'(obs_busy), 64'd1);
        chk("s4_reset.lo_before", 64'(obs_out_lo), 64'hFFFFFFFD);
        #3;
        resetn = 1'b0;
        #1;
        chk("s4_reset.in_ready", 64'(obs_in_ready), 64'd1);
        chk("s4_reset.busy", 64'(obs_busy), 64'd0);
        chk("s4_reset.out_valid", 64'(obs_out_valid), 64'd0);
        chk("s4_reset.out_hi", 64'(obs_out_hi), 64'd0);
        chk("s4_reset.out_lo", 64'(obs_out_lo), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        do_op("s4_after_reset", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 0);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
